// File: rtl/fu_pkg.sv
// Shared definitions for the function unit and its sequencer: FS codes,
// datapath widths and the sequencer state encoding.
package fu_pkg;

    localparam int DW  = 32;
    localparam int SHW = 5;

    localparam logic [4:0] FS_PASS_A  = 5'b00000;
    localparam logic [4:0] FS_ADD     = 5'b00010;
    localparam logic [4:0] FS_ADD_INC = 5'b00101;
    localparam logic [4:0] FS_INC_A   = 5'b00111;
    localparam logic [4:0] FS_AND     = 5'b01000;
    localparam logic [4:0] FS_OR      = 5'b01010;
    localparam logic [4:0] FS_XOR     = 5'b01100;
    localparam logic [4:0] FS_SHR     = 5'b10000;
    localparam logic [4:0] FS_SHL     = 5'b10001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } fu_seq_state_t;

    function automatic logic is_shift(input logic [4:0] fs,
                                      input logic [4:0] shr_fs,
                                      input logic [4:0] shl_fs);
        return (fs == shr_fs) || (fs == shl_fs);
    endfunction

endpackage

// File: rtl/fu_sequencer.sv
// Multi-cycle controller driving the combinational function unit; shifts run as
// iterated 1-bit passes. Optional macro FU_SEQ_FAST_PATH_EN: single-edge non-shift ops.
module fu_sequencer #(
    parameter int         DW     = fu_pkg::DW,
    parameter int         SHW    = fu_pkg::SHW,
    parameter logic [4:0] SHR_FS = fu_pkg::FS_SHR,
    parameter logic [4:0] SHL_FS = fu_pkg::FS_SHL
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [4:0]     op_fs,
    input  logic [DW-1:0]  op_a,
    input  logic [DW-1:0]  op_b,
    input  logic [SHW-1:0] op_sh,
    output logic [DW-1:0]  fu_a,
    output logic [DW-1:0]  fu_b,
    output logic [SHW-1:0] fu_sh,
    output logic [4:0]     fu_fs,
    input  logic [DW-1:0]  fu_f,
    input  logic           fu_z,
    input  logic           fu_n,
    input  logic           fu_v,
    input  logic           fu_c,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [DW-1:0]  res_f,
    output logic           res_z,
    output logic           res_n,
    output logic           res_v,
    output logic           res_c,
    output logic           busy
);
    import fu_pkg::*;

    // Handshakes: a request transfers on the edge where op_valid && op_ready;
    // a result transfers on the edge where res_valid && res_ready. Neither
    // valid depends combinationally on its ready.
    fu_seq_state_t  state;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  b_q;
    logic [SHW-1:0] sh_q;
    logic [SHW-1:0] cnt;
    logic [4:0]     fs_q;
    logic           op_shift;
    logic           op_zero_sh;
    logic           accept;
    logic [4:0]     op_fs_eff;

    assign op_ready   = (state == S_IDLE);
    assign accept     = op_valid && op_ready;
    assign op_shift   = is_shift(op_fs, SHR_FS, SHL_FS);
    assign op_zero_sh = (op_sh == '0);
    // A zero-length shift degenerates to passing A through.
    assign op_fs_eff  = (op_shift && op_zero_sh) ? FS_PASS_A : op_fs;

    always_comb begin
        fu_a  = a_q;
        fu_b  = b_q;
        fu_sh = sh_q;
        fu_fs = fs_q;
        if (state == S_SHIFT) begin
            fu_sh = SHW'(1);
        end
`ifdef FU_SEQ_FAST_PATH_EN
        if (state == S_IDLE) begin
            fu_a  = op_a;
            fu_b  = op_b;
            fu_sh = op_sh;
            fu_fs = op_fs_eff;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sh_q      <= '0;
            fs_q      <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_f     <= '0;
            res_z     <= 1'b0;
            res_n     <= 1'b0;
            res_v     <= 1'b0;
            res_c     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q  <= op_a;
                        b_q  <= op_b;
                        sh_q <= op_sh;
                        fs_q <= op_fs_eff;
                        cnt  <= op_sh;
                        busy <= 1'b1;
                        if (op_shift && !op_zero_sh) begin
                            state <= S_SHIFT;
                        end else begin
`ifdef FU_SEQ_FAST_PATH_EN
                            res_f     <= fu_f;
                            res_z     <= fu_z;
                            res_n     <= fu_n;
                            res_v     <= fu_v;
                            res_c     <= fu_c;
                            res_valid <= 1'b1;
                            state     <= S_DONE;
`else
                            state <= S_EXEC;
`endif
                        end
                    end
                end
                S_EXEC: begin
                    res_f     <= fu_f;
                    res_z     <= fu_z;
                    res_n     <= fu_n;
                    res_v     <= fu_v;
                    res_c     <= fu_c;
                    res_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_SHIFT: begin
                    // a_q doubles as the working register fed back each pass.
                    a_q <= fu_f;
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        res_f     <= fu_f;
                        res_z     <= fu_z;
                        res_n     <= fu_n;
                        res_v     <= fu_v;
                        res_c     <= fu_c;
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fu_sequencer.sv
// Directed bench for fu_sequencer with a behavioural function-unit model
// attached to the fu_* ports; latencies adapt to FU_SEQ_FAST_PATH_EN.
module tb_fu_sequencer;
    import fu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [4:0]  op_fs = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  op_sh = '0;
    logic [31:0] fu_a, fu_b, fu_f;
    logic [4:0]  fu_sh, fu_fs;
    logic        fu_z, fu_n, fu_v, fu_c;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_f;
    logic        res_z, res_n, res_v, res_c;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

`ifdef FU_SEQ_FAST_PATH_EN
    localparam int LAT_SIMPLE = 1;
`else
    localparam int LAT_SIMPLE = 2;
`endif

    // clock / reset
    always #5 clk = ~clk;

    fu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_fs(op_fs),
        .op_a(op_a), .op_b(op_b), .op_sh(op_sh),
        .fu_a(fu_a), .fu_b(fu_b), .fu_sh(fu_sh), .fu_fs(fu_fs),
        .fu_f(fu_f), .fu_z(fu_z), .fu_n(fu_n), .fu_v(fu_v), .fu_c(fu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_f(res_f),
        .res_z(res_z), .res_n(res_n), .res_v(res_v), .res_c(res_c),
        .busy(busy)
    );

    // behavioural function unit
    logic [32:0] fu_sum;
    always_comb begin
        fu_sum = '0;
        fu_f   = '0;
        fu_c   = 1'b0;
        fu_v   = 1'b0;
        case (fu_fs)
            FS_PASS_A:  fu_f = fu_a;
            FS_ADD:     fu_sum = {1'b0, fu_a} + {1'b0, fu_b};
            FS_ADD_INC: fu_sum = {1'b0, fu_a} + {1'b0, fu_b} + 33'd1;
            FS_INC_A:   fu_sum = {1'b0, fu_a} + 33'd1;
            FS_AND:     fu_f = fu_a & fu_b;
            FS_OR:      fu_f = fu_a | fu_b;
            FS_XOR:     fu_f = fu_a ^ fu_b;
            FS_SHR:     fu_f = fu_a >> fu_sh;
            FS_SHL:     fu_f = fu_a << fu_sh;
            default:    fu_f = '0;
        endcase
        if (fu_fs == FS_ADD || fu_fs == FS_ADD_INC || fu_fs == FS_INC_A) begin
            fu_f = fu_sum[31:0];
            fu_c = fu_sum[32];
            fu_v = (fu_a[31] == fu_b[31]) && (fu_f[31] != fu_a[31]) && (fu_fs != FS_INC_A);
        end
        fu_z = (fu_f == '0);
        fu_n = fu_f[31];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver: present one op, hold until accepted, optionally log its result
    task automatic issue(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] expf, input bit track);
        int w;
        op_fs = fs; op_a = a; op_b = b; op_sh = sh; op_valid = 1'b1;
        w = 0;
        while (!op_ready && w < 50) begin
            tick();
            w++;
        end
        check("op_ready_before_accept", {31'd0, op_ready}, 32'd1);
        tick();
        op_valid = 1'b0; op_fs = '0; op_a = '0; op_b = '0; op_sh = '0;
        if (track) exp_q.push_back(expf);
    endtask

    // wait for res_valid, counting edges since accept and shift passes seen
    task automatic wait_result(input string tag, input int exp_lat, input int exp_shifts);
        int edges;
        int nsh;
        edges = 1;
        nsh = 0;
        while (!res_valid && edges < 100) begin
            if (fu_sh == 5'd1 && (fu_fs == FS_SHR || fu_fs == FS_SHL)) nsh++;
            tick();
            edges++;
        end
        check({tag, "_latency"}, edges, exp_lat);
        check({tag, "_shift_passes"}, nsh, exp_shifts);
    endtask

    // scoreboard: compare against the oldest expected result, then hand it off
    task automatic collect(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check({tag, "_res_f"}, res_f, e);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_res_valid_dropped"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_op_ready_back"}, {31'd0, op_ready}, 32'd1);
    endtask

    logic [31:0] held_f;

    initial begin
        // reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_f", res_f, 32'd0);
        check("rst_fu_a", fu_a, 32'd0);
        check("rst_fu_fs", {27'd0, fu_fs}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD with carry-out wrapping to zero
        issue(FS_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1);
        check("add_busy", {31'd0, busy}, 32'd1);
`ifndef FU_SEQ_FAST_PATH_EN
        check("add_exec_fu_fs", {27'd0, fu_fs}, {27'd0, FS_ADD});
        check("add_exec_fu_a", fu_a, 32'hFFFF_FFFF);
`endif
        wait_result("add", LAT_SIMPLE, 0);
        check("add_res_c", {31'd0, res_c}, 32'd1);
        check("add_res_z", {31'd0, res_z}, 32'd1);
        check("add_res_v", {31'd0, res_v}, 32'd0);
        collect("add");

        // shift right by 4 as four 1-bit passes
        issue(FS_SHR, 32'h8000_0000, 32'h0000_0000, 5'd4, 32'h0800_0000, 1'b1);
        wait_result("shr4", 5, 4);
        check("shr4_res_n", {31'd0, res_n}, 32'd0);
        collect("shr4");

        // shift left by the maximum amount
        issue(FS_SHL, 32'h0000_0003, 32'h0000_0000, 5'd31, 32'h8000_0000, 1'b1);
        wait_result("shl31", 32, 31);
        check("shl31_res_n", {31'd0, res_n}, 32'd1);
        collect("shl31");

        // zero-length shift passes A through
        issue(FS_SHL, 32'h1234_5678, 32'hDEAD_BEEF, 5'd0, 32'h1234_5678, 1'b1);
`ifndef FU_SEQ_FAST_PATH_EN
        check("zsh_exec_fu_fs", {27'd0, fu_fs}, {27'd0, FS_PASS_A});
`endif
        wait_result("zsh", LAT_SIMPLE, 0);
        collect("zsh");

        // backpressure: result holds while a second request is refused
        issue(FS_OR, 32'hF000_0000, 32'h0000_000F, 5'd0, 32'hF000_000F, 1'b1);
        wait_result("bp", LAT_SIMPLE, 0);
        held_f = res_f;
        op_fs = FS_AND; op_a = 32'h5555_5555; op_b = 32'hFFFF_FFFF; op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_res_valid_held", {31'd0, res_valid}, 32'd1);
            check("bp_res_f_held", res_f, 32'hF000_000F);
            check("bp_op_ready_low", {31'd0, op_ready}, 32'd0);
        end
        op_valid = 1'b0; op_fs = '0; op_a = '0; op_b = '0;
        check("bp_res_n", {31'd0, res_n}, 32'd1);
        collect("bp");
        check("bp_busy_cleared", {31'd0, busy}, 32'd0);

        // reset in the middle of a 20-pass shift drops the op
        issue(FS_SHL, 32'h0000_0001, 32'h0000_0000, 5'd20, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("midrst_still_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_op_ready", {31'd0, op_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_res_f", res_f, 32'd0);
        check("midrst_fu_a", fu_a, 32'd0);
        rst_n = 1'b1;
        tick();

        // fresh XOR after the reset
        issue(FS_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, 32'hFFFF_FFFF, 1'b1);
        wait_result("xor", LAT_SIMPLE, 0);
        check("xor_res_n", {31'd0, res_n}, 32'd1);
        check("xor_res_z", {31'd0, res_z}, 32'd0);
        collect("xor");

        // unused FS code passes through and this model yields zero
        issue(5'b11111, 32'h0000_00AA, 32'h0000_0055, 5'd3, 32'h0000_0000, 1'b1);
`ifndef FU_SEQ_FAST_PATH_EN
        check("unused_exec_fu_fs", {27'd0, fu_fs}, 32'h0000_001F);
`endif
        wait_result("unused", LAT_SIMPLE, 0);
        check("unused_res_z", {31'd0, res_z}, 32'd1);
        collect("unused");

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fu_sequencer.md
Name: fu_sequencer

Overview:
- Multi-cycle controller in front of the combinational 32-bit function unit (FS-coded ALU with Z/N/V/C flags).
- Accepts one operation at a time over a valid/ready request channel and drives the function unit's A/B/SH/FS inputs.
- Executes shift codes as iterated 1-bit shifts, feeding each result back as A for the next pass.
- Registers the final F and flags, and presents them on a valid/ready result channel to the writeback stage.

Parameters:
- DW, 32, datapath width; must match the function unit.
- SHW, 5, width of the shift-amount field.
- SHR_FS, 5'b10000, FS code for shift right.
- SHL_FS, 5'b10001, FS code for shift left.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- op_valid  in  1  request valid.
- op_ready  out  1  sequencer idle and able to accept a request.
- op_fs  in  5  function select.
- op_a  in  DW  operand A.
- op_b  in  DW  operand B.
- op_sh  in  SHW  shift amount.
- fu_a  out  DW  A input to the function unit.
- fu_b  out  DW  B input to the function unit.
- fu_sh  out  SHW  SH input to the function unit.
- fu_fs  out  5  FS input to the function unit.
- fu_f  in  DW  F result from the function unit.
- fu_z, fu_n, fu_v, fu_c  in  1 each  function unit flags.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted by the consumer.
- res_f  out  DW  registered result.
- res_z, res_n, res_v, res_c  out  1 each  registered flags.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, EXEC, SHIFT, DONE.
- op_ready = (state == IDLE). The transfer occurs on the clk edge where op_valid && op_ready.
- Reset (rst_n low at a clk edge, in any state, including mid-shift or with DONE stalled):
  - state -> IDLE.
  - res_valid, res_f, res_z/n/v/c, busy, and the iteration counter -> 0.
  - Internal operand registers -> 0, so fu_a/fu_b/fu_sh/fu_fs = 0.
  - Any in-flight op is dropped with no result.
- IDLE:
  - On transfer, latch op_fs/op_a/op_b/op_sh.
  - Non-shift FS -> EXEC.
  - Shift FS with op_sh != 0 -> SHIFT, count = op_sh.
  - Shift FS with op_sh == 0 -> EXEC with FS forced to 5'b00000 (pass A).
- EXEC (one cycle):
  - fu_* driven from the latched operands.
  - At the edge, capture fu_f and fu_z/n/v/c into res_*, then go to DONE.
- SHIFT:
  - fu_fs = latched shift code, fu_sh = 1, fu_a = working register (initially op_a), fu_b = latched B.
  - Each edge: working register <= fu_f, count <= count - 1.
  - When count == 1, also capture fu_f and flags into res_*, then go to DONE.
  - Takes exactly op_sh cycles; the maximum of 31 fits in SHW bits.
- DONE:
  - res_valid = 1, and res_* hold stable until accepted.
  - When res_ready is high at an edge: go to IDLE and drop res_valid.
  - res_ready low: remain in DONE (backpressure). op_ready stays 0.
- Latency from accept edge to res_valid high:
  - Non-shift op: 2 edges.
  - Shift by n: n + 1 edges.
- Throughput: at most one op in flight. The next accept is possible in the cycle after res handshake.
- Unused FS codes are passed through unchanged in EXEC; this is not an error.
- fu_* outputs are combinational from registers only; no combinational path from fu_f back to fu_a.

Optional Feature:
- Macro FU_SEQ_FAST_PATH_EN.
- Defined:
  - Non-shift ops (and shift with op_sh == 0) skip EXEC.
  - fu_* are driven directly from op_* while in IDLE.
  - fu_f and flags are captured on the accept edge, going straight to DONE.
  - Latency becomes 1 edge. Shift behaviour is unchanged.
- Undefined: behaviour exactly as in Behaviour above.

Decomposition:
- Shared package fu_pkg holds:
  - FS encoding constants: FS_PASS_A=00000, FS_ADD=00010, FS_ADD_INC=00101, FS_AND=01000, FS_OR=01010, FS_XOR=01100, FS_INC_A=00111, FS_SHR=10000, FS_SHL=10001.
  - The state enum fu_seq_state_t.
  - DW/SHW constants.
- No sub-module is needed: the counter and FSM fit in one module.
- The function unit is instantiated beside the sequencer in the enclosing datapath, not inside it.

Test Plan:
- ADD: op_fs=00010, a=32'hFFFF_FFFF, b=1 -> res_valid 2 edges after accept, res_f=0, res_c=1; fu_fs=00010 during EXEC.
- Shift: op_fs=10000, a=32'h8000_0000, op_sh=4 -> fu_sh=1 and fu_fs=10000 for exactly 4 cycles, res_valid on edge 5, res_f = four iterated FU shift results.
- Zero shift: op_fs=10001, op_sh=0 -> single EXEC with fu_fs=00000, res_f=op_a, latency 2.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_f stable, op_ready=0 and new op_valid ignored; res_ready=1 -> IDLE next cycle, op_ready=1.
- Reset mid-shift: op_sh=20, rst_n low at iteration 7 -> next cycle state IDLE, res_valid=0, busy=0, res_f=0; a fresh XOR op afterwards completes normally.
- FU_SEQ_FAST_PATH_EN build: XOR a=32'hF0F0_F0F0, b=32'h0F0F_0F0F -> res_valid 1 edge after accept, res_f=32'hFFFF_FFFF.
